// File: rtl/router_ingress.sv
// router_ingress: input stage of the 1x3 router, drives the per-port FIFO write side.
// Define ROUTER_ERR_CNT_EN to add the saturating err_cnt output.
module router_ingress #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int NUM_DEST = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pkt_valid,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [NUM_DEST-1:0] fifo_full,
    output logic                busy,
    output logic [NUM_DEST-1:0] wr_en,
    output logic [DATA_W-1:0]   data_out,
    output logic                pkt_done,
    output logic                parity_err,
    output logic                addr_err
`ifdef ROUTER_ERR_CNT_EN
    ,
    output logic [7:0]          err_cnt
`endif
);

    localparam int LEN_W = DATA_W - ADDR_W;

    localparam logic [1:0] DECODE  = 2'd0;
    localparam logic [1:0] PAYLOAD = 2'd1;
    localparam logic [1:0] PARITY  = 2'd2;
    localparam logic [1:0] DROP    = 2'd3;

    localparam logic [LEN_W-1:0]  CNT_ONE  = LEN_W'(1);
    localparam logic [ADDR_W:0]   DEST_LIM = (ADDR_W+1)'(NUM_DEST);

    logic [1:0]          state;
    logic [ADDR_W-1:0]   dest;
    logic [LEN_W-1:0]    cnt;
    logic [DATA_W-1:0]   par;
    logic [DATA_W-1:0]   hold_data;
    logic                hold_valid;

    logic [NUM_DEST-1:0] dest_oh;
    logic [ADDR_W-1:0]   hdr_dest;
    logic [LEN_W-1:0]    hdr_len;
    logic                hdr_ok;
    logic                accept;
    logic                write;
    logic                load;

    assign hdr_dest = data_in[ADDR_W-1:0];
    assign hdr_len  = data_in[DATA_W-1:ADDR_W];
    assign hdr_ok   = {1'b0, hdr_dest} < DEST_LIM;

    // One-hot select of the FIFO owned by the packet currently in flight
    always_comb begin
        dest_oh = '0;
        for (int i = 0; i < NUM_DEST; i++) begin
            dest_oh[i] = (dest == ADDR_W'(i));
        end
    end

    // Write side handshake: stall only when the held byte's FIFO is full
    always_comb begin
        busy     = hold_valid & (|(dest_oh & fifo_full));
        wr_en    = hold_valid ? (dest_oh & ~fifo_full) : '0;
        write    = |wr_en;
        accept   = pkt_valid & ~busy;
        load     = 1'b0;
        unique case (state)
            DECODE:  load = accept & hdr_ok;
            PAYLOAD: load = accept;
            PARITY:  load = accept;
            DROP:    load = 1'b0;
        endcase
    end

    assign data_out = hold_data;

    // Hold register: refill on accept, otherwise empty once written
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (load) begin
            hold_valid <= 1'b1;
            hold_data  <= data_in;
        end else if (write) begin
            hold_valid <= 1'b0;
        end
    end

    // Packet framing FSM with running parity and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= DECODE;
            dest       <= '0;
            cnt        <= '0;
            par        <= '0;
            pkt_done   <= 1'b0;
            parity_err <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            pkt_done   <= 1'b0;
            parity_err <= 1'b0;
            addr_err   <= 1'b0;
            if (accept) begin
                unique case (state)
                    DECODE: begin
                        dest <= hdr_dest;
                        cnt  <= hdr_len;
                        par  <= data_in;
                        if (!hdr_ok) begin
                            addr_err <= 1'b1;
                            state    <= DROP;
                        end else if (hdr_len == '0) begin
                            state <= PARITY;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        par <= par ^ data_in;
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_err <= (data_in != par);
                        pkt_done   <= 1'b1;
                        state      <= DECODE;
                    end
                    DROP: begin
                        if (cnt == '0) begin
                            state <= DECODE;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                endcase
            end
        end
    end

`ifdef ROUTER_ERR_CNT_EN
    // Saturating tally of error pulses; coincident pulses count once
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= '0;
        end else if ((parity_err | addr_err) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule
